// File: rtl/fi_pkg.sv
// rtl/fi_pkg.sv - shared types for the fault-injection scheduler
package fi_pkg;

    // Request fields are carried at fixed maximum widths and narrowed by the user.
    localparam int FI_SEL_W = 8;
    localparam int FI_CNT_W = 32;

    typedef enum logic [1:0] {
        FI_STUCK0 = 2'b00,
        FI_STUCK1 = 2'b01,
        FI_FLIP   = 2'b10,
        FI_RSVD   = 2'b11
    } fi_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACTIVE = 2'b10,
        DONE   = 2'b11
    } fi_state_e;

    typedef struct packed {
        logic [FI_SEL_W-1:0] sel;
        fi_mode_e            mode;
        logic [FI_CNT_W-1:0] delay;
        logic [FI_CNT_W-1:0] len;
    } fi_cfg_t;

endpackage

// File: rtl/fi_down_counter.sv
// rtl/fi_down_counter.sv - loadable down-counter, holds at zero, flags the final count
module fi_down_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_last = (r_count == CNT_W'(1));
    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mux_fault_sched.sv
// rtl/mux_fault_sched.sv - single-campaign fault-injection scheduler driving per-cell force flag/value pairs
module mux_fault_sched
    import fi_pkg::*;
#(
    parameter  int NUM_CELLS = 8,
    parameter  int CNT_W     = 16,
    localparam int SEL_W     = $clog2(NUM_CELLS)
) (
    input  logic                 C,
    input  logic                 CLR,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [SEL_W-1:0]     cfg_sel,
    input  logic [1:0]           cfg_mode,
    input  logic [CNT_W-1:0]     cfg_delay,
    input  logic [CNT_W-1:0]     cfg_len,
    input  logic                 abort,
    input  logic [NUM_CELLS-1:0] nom_in,
    output logic [NUM_CELLS-1:0] force_f,
    output logic [NUM_CELLS-1:0] force_v,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     inj_count
);

    fi_cfg_t              w_req;
    logic                 w_bad;
    logic                 w_accept;
    fi_state_e            r_state;
    fi_state_e            w_state_nxt;
    logic [SEL_W-1:0]     r_sel;
    fi_mode_e             r_mode;
    logic [CNT_W-1:0]     r_len;
    logic                 r_len_zero;
    logic [NUM_CELLS-1:0] w_onehot;
    logic [NUM_CELLS-1:0] w_fv;
    logic [NUM_CELLS-1:0] r_force_f;
    logic [NUM_CELLS-1:0] r_force_v;
    logic                 r_done;
    logic                 r_err;
    logic [CNT_W-1:0]     r_inj_count;
    logic                 w_cnt_load;
    logic [CNT_W-1:0]     w_cnt_val;
    logic                 w_cnt_dec;
    logic                 w_cnt_last;
    logic                 w_cnt_zero;
    logic                 w_force_on;

    always_comb begin
        w_req.sel   = FI_SEL_W'(cfg_sel);
        w_req.mode  = fi_mode_e'(cfg_mode);
        w_req.delay = FI_CNT_W'(cfg_delay);
        w_req.len   = FI_CNT_W'(cfg_len);
    end

    assign w_bad    = (w_req.mode == FI_RSVD) || (w_req.sel >= FI_SEL_W'(NUM_CELLS));
    assign w_accept = (r_state == IDLE) && cfg_valid;

    always_comb begin
        for (int i = 0; i < NUM_CELLS; i++) begin
            w_onehot[i] = (r_sel == SEL_W'(i));
        end
    end

    // Bit-flip inverts the live nominal value; the register below adds the one-cycle lag.
    always_comb begin
        case (r_mode)
            FI_STUCK1: w_fv = w_onehot;
            FI_FLIP:   w_fv = w_onehot & ~nom_in;
            default:   w_fv = '0;
        endcase
    end

    // A zero delay is treated as one so the fault never starts on the acceptance edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;
        w_force_on  = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_valid && !w_bad) begin
                    w_state_nxt = WAIT;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = (w_req.delay == '0) ? CNT_W'(1) : w_req.delay[CNT_W-1:0];
                end
            end
            WAIT: begin
                if (abort) begin
                    w_state_nxt = DONE;
                end else if (w_cnt_last) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = r_len;
                    w_force_on  = !r_len_zero;
                end
            end
            ACTIVE: begin
                if (abort || w_cnt_last || w_cnt_zero) begin
                    w_state_nxt = DONE;
                end else begin
                    w_force_on = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_cnt_dec = (r_state == WAIT) || (r_state == ACTIVE);

    fi_down_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .i_clk      (C),
        .i_rst      (CLR),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_last     (w_cnt_last),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_mode      <= FI_STUCK0;
            r_len       <= '0;
            r_len_zero  <= 1'b0;
            r_force_f   <= '0;
            r_force_v   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_inj_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= (w_state_nxt == DONE) || (w_accept && w_bad);
            r_force_f <= w_force_on ? w_onehot : '0;
            r_force_v <= w_force_on ? w_fv : '0;
            if (w_accept) begin
                r_sel      <= w_req.sel[SEL_W-1:0];
                r_mode     <= w_req.mode;
                r_len      <= w_req.len[CNT_W-1:0];
                r_len_zero <= (w_req.len == '0);
                if (w_bad) begin
                    r_err <= 1'b1;
                end
            end
            if ((r_state == ACTIVE) && (w_state_nxt == DONE) && !abort) begin
                r_inj_count <= r_inj_count + CNT_W'(1);
            end
        end
    end

    assign cfg_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign force_f   = r_force_f;
    assign force_v   = r_force_v;
    assign done      = r_done;
    assign err       = r_err;
    assign inj_count = r_inj_count;

endmodule
